// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register plus operand preparation for the
// EX stage of a 5-stage MIPS datapath. Decodes the ALU control code at capture,
// forwards EX/MEM and MEM/WB results combinationally onto the ALU operands, and
// raises a one-cycle stall for load-use pairs while inserting a bubble.
module ex_operand_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_aluop,
    input  logic [5:0]  id_funct,
    input  logic        id_alusrc,
    input  logic        id_regdst,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        flush,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        hazard_stall,
    output logic        ex_valid,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] first_operand,
    output logic [31:0] second_operand,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dest,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg
);

    // ALU control code from main-control ALUOp and the R-type funct field.
    // Unknown funct maps to 15, which the ALU treats as "output zero".
    function automatic logic [3:0] alu_decode(input logic [1:0] aluop,
                                              input logic [5:0] funct);
        logic [3:0] code;
        code = 4'd15;
        case (aluop)
            2'b00: code = 4'd2;
            2'b01: code = 4'd6;
            2'b11: code = 4'd1;
            default: begin
                case (funct)
                    6'b100000: code = 4'd2;
                    6'b100010: code = 4'd6;
                    6'b100100: code = 4'd0;
                    6'b100101: code = 4'd1;
                    6'b100111: code = 4'd12;
                    6'b101010: code = 4'd7;
                    default:   code = 4'd15;
                endcase
            end
        endcase
        return code;
    endfunction

    // Forwarding mux for one source register; the younger EX/MEM result wins,
    // and $0 is never forwarded since its architectural value is always zero.
    function automatic logic [31:0] fwd_sel(input logic [4:0]  src,
                                            input logic [31:0] latched,
                                            input logic        em_we,
                                            input logic [4:0]  em_rd,
                                            input logic [31:0] em_res,
                                            input logic        mw_we,
                                            input logic [4:0]  mw_rd,
                                            input logic [31:0] mw_res);
        logic [31:0] val;
        if (em_we && (em_rd != 5'd0) && (em_rd == src))
            val = em_res;
        else if (mw_we && (mw_rd != 5'd0) && (mw_rd == src))
            val = mw_res;
        else
            val = latched;
        return val;
    endfunction

    logic        valid_q,    valid_d;
    logic [31:0] rs_data_q,  rs_data_d;
    logic [31:0] rt_data_q,  rt_data_d;
    logic [31:0] ext_imm_q,  ext_imm_d;
    logic [4:0]  rs_q,       rs_d;
    logic [4:0]  rt_q,       rt_d;
    logic [4:0]  dest_q,     dest_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic        alusrc_q,   alusrc_d;
    logic        regwrite_q, regwrite_d;
    logic        memread_q,  memread_d;
    logic        memwrite_q, memwrite_d;
    logic        memtoreg_q, memtoreg_d;

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Load-use detection from current EX state; rt is compared even for
    // I-type consumers, which can cost a needless stall but is always safe.
    always_comb begin
        hazard_stall = valid_q && memread_q && id_valid && (dest_q != 5'd0) &&
                       ((dest_q == id_rs) || (dest_q == id_rt));
    end

    // Next-state selection: flush or stall inserts an all-zero bubble,
    // otherwise capture ID with control bits masked by id_valid.
    always_comb begin
        valid_d    = 1'b0;
        rs_data_d  = 32'd0;
        rt_data_d  = 32'd0;
        ext_imm_d  = 32'd0;
        rs_d       = 5'd0;
        rt_d       = 5'd0;
        dest_d     = 5'd0;
        alu_ctrl_d = 4'd0;
        alusrc_d   = 1'b0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        if (!(flush || hazard_stall)) begin
            valid_d    = id_valid;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            ext_imm_d  = (id_aluop == 2'b11) ? {16'd0, id_imm}
                                             : {{16{id_imm[15]}}, id_imm};
            rs_d       = id_rs;
            rt_d       = id_rt;
            dest_d     = id_regdst ? id_rd : id_rt;
            alu_ctrl_d = alu_decode(id_aluop, id_funct);
            alusrc_d   = id_valid && id_alusrc;
            regwrite_d = id_valid && id_regwrite;
            memread_d  = id_valid && id_memread;
            memwrite_d = id_valid && id_memwrite;
            memtoreg_d = id_valid && id_memtoreg;
        end
    end

    // ID/EX register; reset takes priority over flush/stall/capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs_data_q  <= 32'd0;
            rt_data_q  <= 32'd0;
            ext_imm_q  <= 32'd0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            dest_q     <= 5'd0;
            alu_ctrl_q <= 4'd0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            ext_imm_q  <= ext_imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            dest_q     <= dest_d;
            alu_ctrl_q <= alu_ctrl_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
        end
    end

    // Combinational forwarding and operand/control outputs to the ALU and EX/MEM.
    always_comb begin
        fwd_rs = fwd_sel(rs_q, rs_data_q, exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result);
        fwd_rt = fwd_sel(rt_q, rt_data_q, exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result);
        first_operand  = fwd_rs;
        ex_store_data  = fwd_rt;
        second_operand = alusrc_q ? ext_imm_q : fwd_rt;
        ex_valid       = valid_q;
        alu_ctrl       = alu_ctrl_q;
        ex_dest        = dest_q;
        ex_regwrite    = regwrite_q && valid_q;
        ex_memread     = memread_q && valid_q;
        ex_memwrite    = memwrite_q && valid_q;
        ex_memtoreg    = memtoreg_q;
    end

endmodule
